// File: rtl/sha256_compress_iter.sv
// rtl/sha256_compress_iter.sv - iterative SHA-256 compression, UNROLL rounds per clock
// Message schedule is expanded on the fly from a 16-word sliding window.
module sha256_compress_iter #(
  parameter int UNROLL = 1,
  parameter bit ADD_IV = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] state_in,
  input  logic [511:0] block_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] state_out
);
  generate
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
      $error("sha256_compress_iter: UNROLL must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [5:0] LAST_CNT = 6'(64 - UNROLL);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t      st;
  logic [5:0]  cnt;
  logic [31:0] wv  [8];
  logic [31:0] iv  [8];
  logic [31:0] win [16];
  logic [31:0] nxt_wv  [8];
  logic [31:0] nxt_win [16];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ep0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] ep1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // ext holds the window plus the UNROLL words appended this edge; later words
  // may depend on earlier appended ones when UNROLL > 2.
  always_comb begin
    logic [31:0] ext [16+UNROLL];
    logic [31:0] t1;
    logic [31:0] t2;
    for (int i = 0; i < 16; i++) ext[i] = win[i];
    for (int j = 0; j < UNROLL; j++)
      ext[16+j] = sig1(ext[14+j]) + ext[9+j] + sig0(ext[1+j]) + ext[j];
    for (int i = 0; i < 8; i++) nxt_wv[i] = wv[i];
    t1 = '0;
    t2 = '0;
    for (int k = 0; k < UNROLL; k++) begin
      t1 = nxt_wv[7] + ep1(nxt_wv[4]) + ((nxt_wv[4] & nxt_wv[5]) ^ (~nxt_wv[4] & nxt_wv[6]))
           + K[cnt + 6'(k)] + ext[k];
      t2 = ep0(nxt_wv[0]) + ((nxt_wv[0] & nxt_wv[1]) ^ (nxt_wv[0] & nxt_wv[2]) ^ (nxt_wv[1] & nxt_wv[2]));
      nxt_wv[7] = nxt_wv[6];
      nxt_wv[6] = nxt_wv[5];
      nxt_wv[5] = nxt_wv[4];
      nxt_wv[4] = nxt_wv[3] + t1;
      nxt_wv[3] = nxt_wv[2];
      nxt_wv[2] = nxt_wv[1];
      nxt_wv[1] = nxt_wv[0];
      nxt_wv[0] = t1 + t2;
    end
    for (int i = 0; i < 16; i++) nxt_win[i] = ext[i+UNROLL];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      state_out <= '0;
      for (int i = 0; i < 8; i++) begin
        wv[i] <= '0;
        iv[i] <= '0;
      end
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      case (st)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < 8; i++) begin
              wv[i] <= state_in[32*i +: 32];
              iv[i] <= state_in[32*i +: 32];
            end
            for (int i = 0; i < 16; i++) win[i] <= block_in[32*i +: 32];
            cnt  <= '0;
            busy <= 1'b1;
            st   <= ROUND;
          end
        end
        ROUND: begin
          wv  <= nxt_wv;
          win <= nxt_win;
          cnt <= cnt + 6'(UNROLL);
          if (cnt == LAST_CNT) st <= FINAL;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++)
            state_out[32*i +: 32] <= ADD_IV ? (iv[i] + wv[i]) : wv[i];
          done <= 1'b1;
          busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_compress_iter.sv
// tb/tb_sha256_compress_iter.sv - directed checks of sha256_compress_iter over all unroll factors
module tb_sha256_compress_iter;
  localparam logic [255:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                 32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [255:0] DIGEST = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                     32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
  localparam logic [511:0] ABC_BLK = {32'h00000018, 448'h0, 32'h61626380};
  localparam logic [511:0] ALT_BLK = {16{32'hdeadbeef}};
  localparam logic [511:0] BLK1 = {32'h00000000, 32'h80000000, 32'h6e6f7071, 32'h6d6e6f70,
                                   32'h6c6d6e6f, 32'h6b6c6d6e, 32'h6a6b6c6d, 32'h696a6b6c,
                                   32'h68696a6b, 32'h6768696a, 32'h66676869, 32'h65666768,
                                   32'h64656667, 32'h63646566, 32'h62636465, 32'h61626364};
  localparam logic [511:0] BLK2 = {32'h000001c0, 480'h0};
  localparam logic [255:0] H1 = {32'hf20e533a, 32'hcc4b32c1, 32'hcac5f811, 32'h76e09589,
                                 32'h624cde5c, 32'h3363376a, 32'h417a1795, 32'h85e655d6};
  localparam logic [255:0] H2 = {32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
                                 32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61};
  localparam int LAT [4] = '{65, 33, 17, 9};

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] state_in;
  logic [511:0] block_in;
  logic [4:0]   busy;
  logic [4:0]   done;
  logic [255:0] state_out [5];

  int checks = 0;
  int errors = 0;
  int lat  [5];
  int dcnt [5];
  int bcnt [5];
  logic [255:0] res [5];

  always #5 clk = ~clk;

  sha256_compress_iter #(.UNROLL(1), .ADD_IV(1'b1)) u_u1 (.clk(clk), .reset(reset), .start(start),
    .state_in(state_in), .block_in(block_in), .busy(busy[0]), .done(done[0]), .state_out(state_out[0]));
  sha256_compress_iter #(.UNROLL(2), .ADD_IV(1'b1)) u_u2 (.clk(clk), .reset(reset), .start(start),
    .state_in(state_in), .block_in(block_in), .busy(busy[1]), .done(done[1]), .state_out(state_out[1]));
  sha256_compress_iter #(.UNROLL(4), .ADD_IV(1'b1)) u_u4 (.clk(clk), .reset(reset), .start(start),
    .state_in(state_in), .block_in(block_in), .busy(busy[2]), .done(done[2]), .state_out(state_out[2]));
  sha256_compress_iter #(.UNROLL(8), .ADD_IV(1'b1)) u_u8 (.clk(clk), .reset(reset), .start(start),
    .state_in(state_in), .block_in(block_in), .busy(busy[3]), .done(done[3]), .state_out(state_out[3]));
  sha256_compress_iter #(.UNROLL(1), .ADD_IV(1'b0)) u_noiv (.clk(clk), .reset(reset), .start(start),
    .state_in(state_in), .block_in(block_in), .busy(busy[4]), .done(done[4]), .state_out(state_out[4]));

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] sub_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] - y[32*i +: 32];
    return r;
  endfunction

  // Starts all instances on the "abc" block and observes n cycles after acceptance;
  // pa/pb pulse start with other data, rst_at pulses reset (-1 disables).
  task automatic run_op(input int n, input int pa, input int pb, input int rst_at);
    for (int i = 0; i < 5; i++) begin
      lat[i] = -1; dcnt[i] = 0; bcnt[i] = 0; res[i] = '0;
    end
    state_in = IV;
    block_in = ABC_BLK;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c <= n; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (busy[i]) bcnt[i]++;
        if (done[i]) begin
          dcnt[i]++;
          if (lat[i] < 0) begin
            lat[i] = c;
            res[i] = state_out[i];
          end
        end
      end
      start = (c == pa) || (c == pb);
      if (start) begin
        state_in = ~IV;
        block_in = ALT_BLK;
      end
      reset = (c == rst_at);
      @(negedge clk);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int l1, l2;
    logic gap_busy;
    logic [255:0] o1, o2;
    reset = 1'b1;
    start = 1'b0;
    state_in = '0;
    block_in = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) check($sformatf("reset state_out[%0d]", i), state_out[i], 256'h0);
    check("reset busy", 256'(busy), 256'h0);
    check("reset done", 256'(done), 256'h0);
    reset = 1'b0;
    @(negedge clk);

    run_op(80, -1, -1, -1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d digest", 1 << i), res[i], DIGEST);
      check($sformatf("u%0d latency", 1 << i), 256'(lat[i]), 256'(LAT[i]));
      check($sformatf("u%0d busy cycles", 1 << i), 256'(bcnt[i]), 256'(LAT[i]));
    end
    check("noiv digest", res[4], sub_words(DIGEST, IV));
    check("noiv a word", 256'(res[4][31:0]), 256'(32'h506e3058));
    check("noiv latency", 256'(lat[4]), 256'd65);
    repeat (5) @(negedge clk);

    run_op(80, 3, 40, -1);
    check("busy start digest", res[0], DIGEST);
    check("busy start latency", 256'(lat[0]), 256'd65);
    check("busy start done count", 256'(dcnt[0]), 256'd1);
    check("busy start noiv digest", res[4], sub_words(DIGEST, IV));
    repeat (20) @(negedge clk);

    run_op(80, -1, -1, 20);
    check("abort busy cycles", 256'(bcnt[0]), 256'd21);
    check("abort done count", 256'(dcnt[0]), 256'd0);
    check("abort u2 done count", 256'(dcnt[1]), 256'd0);
    check("abort state_out", state_out[0], 256'h0);
    run_op(80, -1, -1, -1);
    check("after abort digest", res[0], DIGEST);
    check("after abort latency", 256'(lat[0]), 256'd65);
    repeat (5) @(negedge clk);

    l1 = -1; l2 = -1; gap_busy = 1'b0; o1 = '0; o2 = '0;
    state_in = IV;
    block_in = BLK1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c <= 50; c++) begin
      if (done[2]) begin
        if (l1 < 0) begin
          l1 = c;
          o1 = state_out[2];
          state_in = H1;
          block_in = BLK2;
        end else if (l2 < 0) begin
          l2 = c;
          o2 = state_out[2];
        end
      end
      if (l1 >= 0 && c == l1 + 1) gap_busy = busy[2];
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b first digest", o1, H1);
    check("b2b first latency", 256'(l1), 256'd17);
    check("b2b accepted in done cycle", 256'(gap_busy), 256'd1);
    check("b2b second latency", 256'(l2), 256'd35);
    check("b2b final digest", o2, H2);
    repeat (80) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
